// File: rtl/video_types.sv
// video_types: shared video-subsystem constants and the OAM DMA state encoding
package video_types;
  localparam logic [15:0] OAM_LOC      = 16'hFE00;
  localparam int          OAM_SIZE     = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} dma_state_t;
endpackage

// File: rtl/oam_dma.sv
// oam_dma: DataBus initiator copying XFER_LEN bytes from a CPU-selected page into OAM; optional OAM_DMA_RESTART_EN makes a busy register write restart the copy
module oam_dma
  import video_types::*;
#(
  parameter logic [15:0] OAM_BASE = OAM_LOC,
  parameter int          XFER_LEN = OAM_SIZE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_we,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] m_addr,
  output logic        m_rd,
  output logic        m_wr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  output logic        busy
);
  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);
  dma_state_t  r_state, w_next;
  logic [7:0]  r_idx, w_idx;
  logic [7:0]  r_hi, w_hi;
  logic [7:0]  r_data, r_reg;
  logic [15:0] r_addr;
  logic [7:0]  w_hi_in;
  logic        w_rd, w_wr;
  assign w_hi_in   = (reg_wdata > 8'hDF) ? reg_wdata - 8'h20 : reg_wdata;
  assign busy      = r_state != IDLE;
  assign bus_req   = busy;
  assign m_rd      = w_rd;
  assign m_wr      = w_wr;
  assign m_addr    = r_addr;
  assign m_wdata   = r_data;
  assign reg_rdata = r_reg;
  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // next state, index/source update and grant-qualified strobes
  always_comb begin
    w_next = r_state;
    w_idx  = r_idx;
    w_hi   = r_hi;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    case (r_state)
      IDLE: if (reg_we) begin
        w_next = READ;
        w_idx  = 8'h00;
        w_hi   = w_hi_in;
      end
      READ: if (bus_gnt) begin
        w_rd   = 1'b1;
        w_next = CAPTURE;
      end
      CAPTURE: w_next = WRITE;
      WRITE: if (bus_gnt) begin
        w_wr   = 1'b1;
        w_next = (r_idx == LAST) ? IDLE : READ;
        w_idx  = (r_idx == LAST) ? r_idx : r_idx + 8'h01;
      end
      default: w_next = IDLE;
    endcase
`ifdef OAM_DMA_RESTART_EN
    if (reg_we && r_state != IDLE) begin
      w_next = READ;
      w_idx  = 8'h00;
      w_hi   = w_hi_in;
    end
`endif
  end
  // datapath registers; address is prepared one edge ahead of the state that drives it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idx  <= 8'h00;
      r_hi   <= 8'h00;
      r_data <= 8'h00;
      r_reg  <= 8'h00;
      r_addr <= 16'h0000;
    end else begin
      r_idx <= w_idx;
      r_hi  <= w_hi;
      if (reg_we) r_reg <= reg_wdata;
      if (r_state == CAPTURE && w_next == WRITE) r_data <= m_rdata;
      if (w_next != IDLE) r_addr <= (w_next == READ) ? {w_hi, w_idx} : OAM_BASE + {8'h00, w_idx};
    end
  end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: table-driven and scenario checks for the OAM DMA engine against a bus/memory model
module tb_oam_dma;
  import video_types::*;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reg_we = 1'b0;
  logic [7:0]  reg_wdata = 8'h00;
  logic        bus_gnt = 1'b1;
  logic [7:0]  reg_rdata, m_wdata;
  logic [7:0]  rdq = 8'h00;
  logic [15:0] m_addr;
  logic        bus_req, m_rd, m_wr, busy;
  logic [7:0]  srcm [0:65535];
  logic [7:0]  oam [0:255];
  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];
  int          total = 0;
  int          bad = 0;
  bit          armed = 1'b0;
  typedef struct {
    logic [7:0]  w;
    logic [15:0] first;
    logic [15:0] last;
  } vec_t;
  vec_t tbl [7];

  oam_dma dut (
    .clk(clk), .reset_n(reset_n), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .bus_req(bus_req), .bus_gnt(bus_gnt), .m_addr(m_addr),
    .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata), .m_rdata(rdq), .busy(busy)
  );

  always #5 clk = ~clk;

  // bus target: source memory returns data the cycle after m_rd; OAM captures writes
  always @(posedge clk) begin
    if (m_rd) rdq <= srcm[m_addr];
    if (m_wr && m_addr[15:8] == 8'hFE) oam[m_addr[7:0]] <= m_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // strobe rules and transaction log, sampled mid-cycle
  always @(negedge clk) if (armed) begin
    chk("excl", 32'(m_rd & m_wr), 32'd0);
    chk("strobe_no_gnt", 32'((m_rd | m_wr) & ~bus_gnt), 32'd0);
    if (m_rd) rd_q.push_back(m_addr);
    if (m_wr) wr_q.push_back(m_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [7:0] w, input int mode, output int cyc);
    rd_q.delete();
    wr_q.delete();
    bus_gnt = 1'b1;
    reg_we = 1'b1;
    reg_wdata = w;
    tick;
    reg_we = 1'b0;
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      bus_gnt = !(mode == 1 && ((cyc >= 121 && cyc <= 125) || (cyc >= 128 && cyc <= 132)));
      if (mode == 2 && cyc == 241) begin
        reset_n = 1'b0;
        tick;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_rd", 32'(m_rd), 32'd0);
        chk("rst_wr", 32'(m_wr), 32'd0);
        chk("rst_addr", 32'(m_addr), 32'd0);
        chk("rst_wdata", 32'(m_wdata), 32'd0);
        chk("rst_reg", 32'(reg_rdata), 32'd0);
        reset_n = 1'b1;
      end else begin
        if (mode == 3 && cyc == 151) begin
          reg_we = 1'b1;
          reg_wdata = 8'hD0;
        end
        tick;
        reg_we = 1'b0;
      end
    end
    bus_gnt = 1'b1;
    chk("timeout", 32'(busy), 32'd0);
  endtask

  task automatic chk_copy(input string name, input logic [7:0] hi);
    int e = 0;
    int nr = rd_q.size();
    int nw = wr_q.size();
    for (int i = 0; i < 160; i++) if (oam[i] !== srcm[{hi, 8'(i)}]) e++;
    chk({name, "_oam"}, 32'(e), 32'd0);
    e = 0;
    if (nr < 160 || nw < 160) e = 999;
    else for (int i = 0; i < 160; i++) begin
      if (rd_q[nr-160+i] !== {hi, 8'(i)}) e++;
      if (wr_q[nw-160+i] !== 16'hFE00 + 16'(i)) e++;
    end
    chk({name, "_order"}, 32'(e), 32'd0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 65536; i++) srcm[i] = 8'($urandom);
    tbl[0] = '{8'hC0, 16'hC000, 16'hC09F};
    tbl[1] = '{8'hE1, 16'hC100, 16'hC19F};
    tbl[2] = '{8'hDF, 16'hDF00, 16'hDF9F};
    tbl[3] = '{8'hE0, 16'hC000, 16'hC09F};
    tbl[4] = '{8'hFE, 16'hDE00, 16'hDE9F};
    tbl[5] = '{8'h00, 16'h0000, 16'h009F};
    tbl[6] = '{8'hFF, 16'hDF00, 16'hDF9F};
    repeat (3) tick;
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_req", 32'(bus_req), 32'd0);
    chk("init_rd", 32'(m_rd), 32'd0);
    chk("init_wr", 32'(m_wr), 32'd0);
    chk("init_addr", 32'(m_addr), 32'd0);
    chk("init_wdata", 32'(m_wdata), 32'd0);
    chk("init_reg", 32'(reg_rdata), 32'd0);
    reset_n = 1'b1;
    armed = 1'b1;
    tick;
    for (int v = 0; v < 7; v++) begin
      run(tbl[v].w, 0, cyc);
      chk("tbl_cycles", 32'(cyc), 32'd480);
      chk("tbl_first", 32'(rd_q.size() > 0 ? rd_q[0] : 16'hxxxx), 32'(tbl[v].first));
      chk("tbl_last", 32'(rd_q.size() > 0 ? rd_q[rd_q.size()-1] : 16'hxxxx), 32'(tbl[v].last));
      chk("tbl_nrd", 32'(rd_q.size()), 32'd160);
      chk("tbl_reg", 32'(reg_rdata), 32'(tbl[v].w));
      chk_copy("tbl", tbl[v].first[15:8]);
    end
    run(8'hC0, 1, cyc);
    chk("stall_cycles", 32'(cyc), 32'd490);
    chk("stall_nrd", 32'(rd_q.size()), 32'd160);
    chk_copy("stall", 8'hC0);
    run(8'hC0, 2, cyc);
    chk("rst_cycle", 32'(cyc), 32'd241);
    tick;
    run(8'hC0, 0, cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd480);
    chk_copy("post_rst", 8'hC0);
    run(8'hC0, 3, cyc);
    chk("rewrite_reg", 32'(reg_rdata), 32'h0000_00D0);
    chk("rewrite_rd50", 32'(rd_q.size() > 50 ? rd_q[50] : 16'hxxxx), 32'h0000_C032);
`ifdef OAM_DMA_RESTART_EN
    chk("rewrite_cycles", 32'(cyc), 32'd631);
    chk("rewrite_rd51", 32'(rd_q.size() > 51 ? rd_q[51] : 16'hxxxx), 32'h0000_D000);
    chk_copy("rewrite", 8'hD0);
`else
    chk("rewrite_cycles", 32'(cyc), 32'd480);
    chk("rewrite_rd51", 32'(rd_q.size() > 51 ? rd_q[51] : 16'hxxxx), 32'h0000_C033);
    chk_copy("rewrite", 8'hC0);
`endif
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
